pcie_irq_sched: RTL and testbench
=================================

PCIE_IRQ_SCHED -- requirements
Module: pcie_irq_sched

Interface
REQ-001 SHALL have parameter C_IRQ_NUM, default 8, meaning number of interrupt requesters (completion queues); legal range 2..32.
REQ-002 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-003 SHALL have port pcie_user_clk  input  1  clock for all logic.
REQ-004 SHALL have port pcie_user_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cfg_interrupt_msi_enable  input  1  1 = MSI mode, 0 = legacy INTx mode.
REQ-006 SHALL have port cfg_interrupt_msi_mmenable  input  3  log2 of the number of MSI vectors the host allocated (0..5).
REQ-007 SHALL have port irq_pend  input  C_IRQ_NUM  level per requester: queue holds unserviced entries and its interrupt is unmasked.
REQ-008 SHALL have port pcie_msi_irq_set  output  1  one-cycle MSI request to the interrupt generator.
REQ-009 SHALL have port pcie_legacy_irq_set  output  1  one-cycle INTx assert request.
REQ-010 SHALL have port pcie_legacy_irq_clear  output  1  level INTx deassert request.
REQ-011 SHALL have port pcie_irq_vector  output  9  vector number for the current request.
REQ-012 SHALL have port pcie_irq_done  input  1  one-cycle completion pulse from the interrupt generator.
REQ-013 SHALL have port irq_busy  output  1  high whenever the FSM is not in S_IDLE.

Function
REQ-014 SHALL use FSM states S_IDLE, S_MSI_ISSUE, S_MSI_WAIT, S_LEG_ISSUE, S_LEG_HOLD, S_LEG_CLEAR.
REQ-015 SHALL sample cfg_interrupt_msi_enable only in S_IDLE; a mode change mid-transaction SHALL take effect at the next S_IDLE.
REQ-016 SHALL keep armed[C_IRQ_NUM-1:0]: armed[i] is cleared when an MSI for requester i is issued, and set in any cycle where irq_pend[i]=0.
REQ-017 In MSI mode, requester i SHALL be eligible when irq_pend[i]=1 and armed[i]=1.
REQ-018 Eligible requesters SHALL be arbitrated round-robin: search starts at last_grant+1 and wraps from C_IRQ_NUM-1 to 0.
REQ-019 S_IDLE -> S_MSI_ISSUE SHALL occur when MSI mode is on and any requester is eligible; last_grant SHALL update to the granted index in the same cycle.
REQ-020 pcie_irq_vector SHALL equal grant & ((1<<mmenable)-1); for mmenable>5, the value 5 is used.
REQ-021 In S_MSI_ISSUE, pcie_msi_irq_set SHALL be 1 for exactly one cycle, then the FSM SHALL go to S_MSI_WAIT.
REQ-022 S_MSI_WAIT SHALL hold pcie_irq_vector stable and return to S_IDLE on pcie_irq_done.
REQ-023 S_IDLE -> S_LEG_ISSUE SHALL occur when MSI mode is off and |irq_pend=1; pcie_legacy_irq_set SHALL pulse for one cycle with pcie_irq_vector=0, then the FSM SHALL go to S_LEG_HOLD.
REQ-024 S_LEG_HOLD -> S_LEG_CLEAR SHALL occur when irq_pend==0.
REQ-025 In S_LEG_CLEAR, pcie_legacy_irq_clear SHALL be held at 1 until pcie_irq_done, then the FSM SHALL go to S_IDLE with clear=0.
REQ-026 Any irq_pend rise during S_LEG_CLEAR SHALL be ignored until S_IDLE, where it triggers a new assert.
REQ-027 All outputs SHALL be registered; request latency SHALL be eligible in S_IDLE at cycle t -> set=1 at t+1.
REQ-028 After pcie_irq_done at cycle t, no set pulse SHALL occur before t+2.
REQ-029 A pcie_irq_done arriving in S_IDLE, S_MSI_ISSUE, S_LEG_ISSUE or S_LEG_HOLD SHALL be ignored.
REQ-030 Requester i SHALL NOT be granted twice without irq_pend[i]=0 between the grants.

Reset
REQ-031 On pcie_user_rst_n=0, state SHALL be S_IDLE; all set, clear, vector and irq_busy outputs SHALL be 0; armed SHALL be all 1; last_grant SHALL be C_IRQ_NUM-1.
REQ-032 Reset mid-transaction SHALL abort immediately with no further set pulses; after release, operation SHALL restart from the REQ-031 values.

Verification
REQ-033 MSI on, mme=3, irq_pend=8'b0000_0101 -> MSI vector 0, done, then vector 2; no third MSI while pend is held.
REQ-034 MSI on, mme=1, pend[6] rises -> pcie_irq_vector=0 (6&1); pend[6] 1->0->1 -> second MSI issued.
REQ-035 MSI off, pend[3]=1 -> one legacy_set pulse; pend held 500 cycles -> no clear; pend=0 -> clear held until done, then irq_busy=0.
REQ-036 MSI on, all 8 pending, set pulse handed done 3 cycles later each time -> grant order 0..7, each set pulse exactly 1 cycle, at least 1 idle cycle between pulses.
REQ-037 Reset asserted in S_MSI_WAIT, then released with pend[0]=1 -> MSI vector 0 issued again, since armed is all 1.
REQ-038 cfg_interrupt_msi_enable toggled 1->0 during S_MSI_WAIT -> current MSI completes; the next request is legacy.

Source files
------------

// File: rtl/pcie_irq_sched.sv
// Interrupt scheduler: round-robin MSI issue per requester with re-arm on idle,
// or single shared legacy INTx assert/deassert handshake.
module pcie_irq_sched #(
  parameter int unsigned C_IRQ_NUM = 8
) (
  input  logic                 pcie_user_clk,
  input  logic                 pcie_user_rst_n,
  input  logic                 cfg_interrupt_msi_enable,
  input  logic [2:0]           cfg_interrupt_msi_mmenable,
  input  logic [C_IRQ_NUM-1:0] irq_pend,
  output logic                 pcie_msi_irq_set,
  output logic                 pcie_legacy_irq_set,
  output logic                 pcie_legacy_irq_clear,
  output logic [8:0]           pcie_irq_vector,
  input  logic                 pcie_irq_done,
  output logic                 irq_busy
);

  localparam int unsigned LG_W = (C_IRQ_NUM > 1) ? $clog2(C_IRQ_NUM) : 1;
  localparam logic [LG_W:0] L_N = (LG_W+1)'(C_IRQ_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSI_ISSUE,
    S_MSI_WAIT,
    S_LEG_ISSUE,
    S_LEG_HOLD,
    S_LEG_CLEAR
  } state_t;

  state_t                 r_state;
  logic [C_IRQ_NUM-1:0]   r_armed;
  logic [LG_W-1:0]        r_last_grant;
  logic                   r_msi_set;
  logic                   r_leg_set;
  logic                   r_leg_clear;
  logic [8:0]             r_vector;
  logic                   r_busy;

  logic [C_IRQ_NUM-1:0]   w_elig;
  logic [C_IRQ_NUM-1:0]   w_rearmed;
  logic [C_IRQ_NUM-1:0]   w_onehot;
  logic                   w_found;
  logic [LG_W-1:0]        w_grant;
  logic [LG_W:0]          w_sum;
  logic [2:0]             w_mme;
  logic [8:0]             w_mask;
  logic [8:0]             w_vec;

  assign w_elig    = irq_pend & r_armed;
  assign w_rearmed = r_armed | ~irq_pend;
  assign w_onehot  = C_IRQ_NUM'(1) << w_grant;

  // Round-robin: first eligible index after last_grant, wrapping at C_IRQ_NUM.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_last_grant;
    w_sum   = '0;
    for (int unsigned k = 1; k <= C_IRQ_NUM; k++) begin
      w_sum = {1'b0, r_last_grant} + (LG_W+1)'(k);
      if (w_sum >= L_N) begin
        w_sum = w_sum - L_N;
      end
      if (!w_found && w_elig[LG_W'(w_sum)]) begin
        w_found = 1'b1;
        w_grant = LG_W'(w_sum);
      end
    end
  end

  assign w_mme  = (cfg_interrupt_msi_mmenable > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable;
  assign w_mask = (9'd1 << w_mme) - 9'd1;
  assign w_vec  = 9'(w_grant) & w_mask;

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      r_state      <= S_IDLE;
      r_armed      <= '1;
      r_last_grant <= LG_W'(C_IRQ_NUM - 1);
      r_msi_set    <= 1'b0;
      r_leg_set    <= 1'b0;
      r_leg_clear  <= 1'b0;
      r_vector     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_armed   <= w_rearmed;
      r_msi_set <= 1'b0;
      r_leg_set <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_interrupt_msi_enable) begin
            if (w_found) begin
              r_state      <= S_MSI_ISSUE;
              r_msi_set    <= 1'b1;
              r_last_grant <= w_grant;
              r_vector     <= w_vec;
              r_armed      <= w_rearmed & ~w_onehot;
              r_busy       <= 1'b1;
            end
          end else if (|irq_pend) begin
            r_state   <= S_LEG_ISSUE;
            r_leg_set <= 1'b1;
            r_vector  <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_MSI_ISSUE: r_state <= S_MSI_WAIT;
        S_MSI_WAIT: begin
          if (pcie_irq_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_LEG_ISSUE: r_state <= S_LEG_HOLD;
        S_LEG_HOLD: begin
          if (irq_pend == '0) begin
            r_state     <= S_LEG_CLEAR;
            r_leg_clear <= 1'b1;
          end
        end
        S_LEG_CLEAR: begin
          if (pcie_irq_done) begin
            r_state     <= S_IDLE;
            r_leg_clear <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_leg_clear <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign pcie_msi_irq_set      = r_msi_set;
  assign pcie_legacy_irq_set   = r_leg_set;
  assign pcie_legacy_irq_clear = r_leg_clear;
  assign pcie_irq_vector       = r_vector;
  assign irq_busy              = r_busy;

endmodule

// File: tb/tb_pcie_irq_sched.sv
// Bench for pcie_irq_sched: directed vector table, multi-cycle scenarios and
// randomized traffic, all compared each cycle against a transaction-level model.
module tb_pcie_irq_sched;

  localparam int unsigned N = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mme;
  logic [7:0] pend;
  logic       done;
  logic       msi_set;
  logic       leg_set;
  logic       leg_clr;
  logic [8:0] vec;
  logic       busy;

  int total;
  int bad;

  pcie_irq_sched #(.C_IRQ_NUM(N)) dut (
    .pcie_user_clk              (clk),
    .pcie_user_rst_n            (rst_n),
    .cfg_interrupt_msi_enable   (en),
    .cfg_interrupt_msi_mmenable (mme),
    .irq_pend                   (pend),
    .pcie_msi_irq_set           (msi_set),
    .pcie_legacy_irq_set        (leg_set),
    .pcie_legacy_irq_clear      (leg_clr),
    .pcie_irq_vector            (vec),
    .pcie_irq_done              (done),
    .irq_busy                   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: an interrupt in flight, whether it is MSI, whether its
  // set pulse is still pending, and whether a legacy release is under way.
  bit          m_act;
  bit          m_msi;
  bit          m_pulse;
  bit          m_rel;
  int unsigned m_last;
  bit [N-1:0]  m_armed;
  logic [8:0]  m_vec;

  function automatic void m_reset();
    m_act   = 0;
    m_msi   = 0;
    m_pulse = 0;
    m_rel   = 0;
    m_last  = N - 1;
    m_armed = '1;
    m_vec   = '0;
  endfunction

  function automatic void m_step();
    bit [N-1:0]  arm_next;
    bit          found;
    int unsigned g;
    int unsigned idx;
    int unsigned mm;
    arm_next = m_armed | ~pend;
    found    = 0;
    g        = 0;
    if (!m_act) begin
      if (en) begin
        for (int unsigned k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && pend[idx] && m_armed[idx]) begin
            found = 1;
            g     = idx;
          end
        end
        if (found) begin
          m_act       = 1;
          m_msi       = 1;
          m_pulse     = 1;
          m_last      = g;
          arm_next[g] = 0;
          mm          = (mme > 3'd5) ? 5 : int'(mme);
          m_vec       = 9'(g % (1 << mm));
        end
      end else if (pend != 0) begin
        m_act   = 1;
        m_msi   = 0;
        m_pulse = 1;
        m_rel   = 0;
        m_vec   = '0;
      end
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (m_msi) begin
      if (done) m_act = 0;
    end else if (!m_rel) begin
      if (pend == 0) m_rel = 1;
    end else if (done) begin
      m_act = 0;
      m_rel = 0;
    end
    m_armed = arm_next;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("msi_set", 32'(msi_set), 32'(m_act && m_msi && m_pulse));
    check("leg_set", 32'(leg_set), 32'(m_act && !m_msi && m_pulse));
    check("leg_clr", 32'(leg_clr), 32'(m_act && m_rel));
    check("vector",  32'(vec),     32'(m_vec));
    check("busy",    32'(busy),    32'(m_act));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_step();
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    cmp_model();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit       en;
    bit [2:0] mme;
    bit [7:0] pend;
    bit       done;
    bit       msi;
    bit       leg;
    bit       clr;
    bit [8:0] vec;
    bit       busy;
  } row_t;

  row_t tbl[$];

  initial begin
    bit found;
    int cnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    mme   = 3'd0;
    pend  = '0;
    done  = 1'b0;
    m_reset();
    tick();
    tick();
    rst_n = 1'b1;

    //         en mme pend   dn  msi leg clr vec busy
    tbl.push_back('{1, 3, 8'h05, 0, 1, 0, 0, 9'd0, 1});
    tbl.push_back('{1, 3, 8'h05, 0, 0, 0, 0, 9'd0, 1});
    tbl.push_back('{1, 3, 8'h05, 1, 0, 0, 0, 9'd0, 0});
    tbl.push_back('{1, 3, 8'h05, 0, 1, 0, 0, 9'd2, 1});
    tbl.push_back('{1, 3, 8'h05, 0, 0, 0, 0, 9'd2, 1});
    tbl.push_back('{1, 3, 8'h05, 1, 0, 0, 0, 9'd2, 0});
    tbl.push_back('{1, 3, 8'h05, 0, 0, 0, 0, 9'd2, 0});
    tbl.push_back('{1, 3, 8'h05, 0, 0, 0, 0, 9'd2, 0});
    tbl.push_back('{1, 1, 8'h40, 0, 1, 0, 0, 9'd0, 1});
    tbl.push_back('{1, 1, 8'h40, 0, 0, 0, 0, 9'd0, 1});
    tbl.push_back('{1, 1, 8'h40, 1, 0, 0, 0, 9'd0, 0});
    tbl.push_back('{1, 1, 8'h40, 0, 0, 0, 0, 9'd0, 0});
    tbl.push_back('{1, 1, 8'h00, 0, 0, 0, 0, 9'd0, 0});
    tbl.push_back('{1, 1, 8'h40, 0, 1, 0, 0, 9'd0, 1});
    tbl.push_back('{1, 1, 8'h40, 1, 0, 0, 0, 9'd0, 1});
    tbl.push_back('{1, 1, 8'h40, 0, 0, 0, 0, 9'd0, 1});
    tbl.push_back('{1, 1, 8'h40, 1, 0, 0, 0, 9'd0, 0});
    tbl.push_back('{0, 1, 8'h08, 0, 0, 1, 0, 9'd0, 1});
    tbl.push_back('{0, 1, 8'h08, 0, 0, 0, 0, 9'd0, 1});
    tbl.push_back('{0, 1, 8'h00, 0, 0, 0, 1, 9'd0, 1});
    tbl.push_back('{0, 1, 8'h08, 0, 0, 0, 1, 9'd0, 1});
    tbl.push_back('{0, 1, 8'h08, 1, 0, 0, 0, 9'd0, 0});
    tbl.push_back('{0, 1, 8'h08, 0, 0, 1, 0, 9'd0, 1});
    tbl.push_back('{0, 1, 8'h08, 0, 0, 0, 0, 9'd0, 1});
    tbl.push_back('{0, 1, 8'h00, 0, 0, 0, 1, 9'd0, 1});
    tbl.push_back('{0, 1, 8'h00, 1, 0, 0, 0, 9'd0, 0});

    foreach (tbl[i]) begin
      en   = tbl[i].en;
      mme  = tbl[i].mme;
      pend = tbl[i].pend;
      done = tbl[i].done;
      tick();
      check($sformatf("tbl%0d_msi", i),  32'(msi_set), 32'(tbl[i].msi));
      check($sformatf("tbl%0d_leg", i),  32'(leg_set), 32'(tbl[i].leg));
      check($sformatf("tbl%0d_clr", i),  32'(leg_clr), 32'(tbl[i].clr));
      check($sformatf("tbl%0d_vec", i),  32'(vec),     32'(tbl[i].vec));
      check($sformatf("tbl%0d_busy", i), 32'(busy),    32'(tbl[i].busy));
    end
    done = 1'b0;

    // Legacy assert held for 500 cycles, then release handshake.
    do_reset();
    en   = 1'b0;
    pend = 8'h08;
    tick();
    check("leg_first_set", 32'(leg_set), 32'd1);
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      cnt += int'(leg_clr) + int'(leg_set);
    end
    check("leg_hold_quiet", 32'(cnt), 32'd0);
    pend = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("leg_clr_held", 32'(leg_clr), 32'd1);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check("leg_clr_drop", 32'(leg_clr), 32'd0);
    check("leg_idle", 32'(busy), 32'd0);

    // All eight requesters pending: grant order 0..7, single-cycle pulses.
    do_reset();
    en   = 1'b1;
    mme  = 3'd5;
    pend = 8'hFF;
    for (int g = 0; g < 8; g++) begin
      found = 0;
      for (int w = 0; w < 10 && !found; w++) begin
        tick();
        if (msi_set) found = 1;
      end
      check("rr_found", 32'(found), 32'd1);
      check("rr_vector", 32'(vec), 32'(g));
      tick();
      check("rr_pulse_width", 32'(msi_set), 32'd0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rr_idle_gap", 32'(busy), 32'd0);
      check("rr_no_set_after_done", 32'(msi_set), 32'd0);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(msi_set);
    end
    check("rr_no_regrant", 32'(cnt), 32'd0);

    // Reset while waiting for completion; armed state restarts all-ones.
    do_reset();
    en   = 1'b1;
    mme  = 3'd3;
    pend = 8'h01;
    tick();
    check("rst_first_set", 32'(msi_set), 32'd1);
    tick();
    check("rst_in_wait", 32'(busy), 32'd1);
    do_reset();
    check("rst_busy_low", 32'(busy), 32'd0);
    tick();
    check("rst_reissue_set", 32'(msi_set), 32'd1);
    check("rst_reissue_vec", 32'(vec), 32'd0);

    // Mode change during a pending MSI applies only after it completes.
    do_reset();
    en   = 1'b1;
    mme  = 3'd3;
    pend = 8'h02;
    tick();
    check("mode_msi_vec", 32'(vec), 32'd1);
    tick();
    en = 1'b0;
    tick();
    check("mode_still_busy", 32'(busy), 32'd1);
    check("mode_no_leg_yet", 32'(leg_set), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("mode_idle", 32'(busy), 32'd0);
    tick();
    check("mode_leg_set", 32'(leg_set), 32'd1);
    check("mode_no_msi", 32'(msi_set), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    en   = 1'b1;
    pend = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) mme = 3'($urandom_range(0, 7));
      pend = pend ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        done = 1'b0;
        do_reset();
      end else begin
        tick();
      end
    end
    done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
